// File: rtl/machine_pkg.sv
// Shared definitions for the enemy-formation ("machine") motion logic:
// position width, direction encoding and default playfield limits.
package machine_pkg;

    localparam int POS_W = 11;

    typedef enum logic [0:0] {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    // Default playfield limits; the renderer and collision logic use these too
    localparam int DEF_X_MIN    = 16;
    localparam int DEF_X_MAX    = 560;
    localparam int DEF_X_INIT   = 16;
    localparam int DEF_STEP     = 8;
    localparam int DEF_MAX_STEP = 32;

endpackage

// File: rtl/machine_edge_det.sv
// Rising-edge detector for a synchronous tick input. The history register
// follows the input even during reset, so a level held through reset is not an edge.
module machine_edge_det (
    input  logic CLK,
    input  logic RST,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge CLK) begin
        in_q <= in;
    end

    assign rise = RST & in & ~in_q;

endmodule

// File: rtl/machine_mover.sv
// Horizontal motion controller for the enemy formation: one step per mueva
// rising edge, clamp and reverse at the limits. Optional MACHINE_SPEEDUP_EN.
module machine_mover
    import machine_pkg::*;
#(
    parameter int X_MIN    = DEF_X_MIN,
    parameter int X_MAX    = DEF_X_MAX,
    parameter int X_INIT   = DEF_X_INIT,
    parameter int STEP     = DEF_STEP,
    parameter int MAX_STEP = DEF_MAX_STEP
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mueva,
    output logic [POS_W-1:0] posx
);

    localparam logic [0:0] S_RIGHT = DIR_RIGHT;
    localparam logic [0:0] S_LEFT  = DIR_LEFT;

    localparam logic [POS_W:0] XMIN_W = (POS_W+1)'(X_MIN);
    localparam logic [POS_W:0] XMAX_W = (POS_W+1)'(X_MAX);

    if (X_MIN >= X_MAX || X_MAX > 2047 || X_INIT < X_MIN || X_INIT > X_MAX ||
        STEP < 1 || STEP > X_MAX - X_MIN || MAX_STEP < STEP) begin : g_bad_params
        $error("machine_mover: illegal parameter set");
    end

    logic             move;
    logic [0:0]       dir;
    logic [POS_W:0]   step;
    logic [POS_W:0]   pos_w;
    logic [POS_W:0]   fwd;
    logic [POS_W:0]   back;
    logic             hit_right;
    logic             hit_left;
    logic             rev;

    machine_edge_det u_edge (
        .CLK  (CLK),
        .RST  (RST),
        .in   (mueva),
        .rise (move)
    );

`ifdef MACHINE_SPEEDUP_EN
    // The reversing move uses the old step; the bump applies from the next move
    always_ff @(posedge CLK) begin
        if (!RST) begin
            step <= (POS_W+1)'(STEP);
        end else if (rev && step < (POS_W+1)'(MAX_STEP)) begin
            step <= step + 1'b1;
        end
    end
`else
    assign step = (POS_W+1)'(STEP);
`endif

    // One extra bit keeps the limit compares free of wrap-around
    assign pos_w     = {1'b0, posx};
    assign fwd       = pos_w + step;
    assign back      = pos_w - step;
    assign hit_right = (fwd >= XMAX_W);
    assign hit_left  = (pos_w <= XMIN_W + step);
    assign rev       = move & ((dir == S_RIGHT) ? hit_right : hit_left);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            posx <= POS_W'(X_INIT);
            dir  <= S_RIGHT;
        end else if (move) begin
            if (dir == S_RIGHT) begin
                if (hit_right) begin
                    posx <= POS_W'(X_MAX);
                    dir  <= S_LEFT;
                end else begin
                    posx <= fwd[POS_W-1:0];
                end
            end else begin
                if (hit_left) begin
                    posx <= POS_W'(X_MIN);
                    dir  <= S_RIGHT;
                end else begin
                    posx <= back[POS_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_machine_mover.sv
// Bench for machine_mover: vector table, bounce sequences, and random
// stimulus against a behavioural position model.
module tb_machine_mover;

    localparam int X_MIN    = 16;
    localparam int X_MAX    = 560;
    localparam int X_INIT   = 16;
    localparam int STEP     = 8;
    localparam int MAX_STEP = 32;

    logic        CLK;
    logic        RST;
    logic        mueva;
    logic [10:0] posx;

    int checks   = 0;
    int failures = 0;

    machine_mover #(
        .X_MIN(X_MIN), .X_MAX(X_MAX), .X_INIT(X_INIT), .STEP(STEP), .MAX_STEP(MAX_STEP)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .mueva (mueva),
        .posx  (posx)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    // Reference model: position plus signed velocity, clamp at the walls
    int m_pos  = X_INIT;
    int m_vel  = STEP;
    bit m_prev = 1'b0;

    always @(posedge CLK) begin
        int nxt;
        int mag;
        if (!RST) begin
            m_pos = X_INIT;
            m_vel = STEP;
        end else if (mueva && !m_prev) begin
            nxt = m_pos + m_vel;
            mag = (m_vel < 0) ? -m_vel : m_vel;
            if (nxt >= X_MAX || nxt <= X_MIN) begin
                m_pos = (nxt >= X_MAX) ? X_MAX : X_MIN;
`ifdef MACHINE_SPEEDUP_EN
                if (mag < MAX_STEP) mag = mag + 1;
`endif
                m_vel = (m_vel > 0) ? -mag : mag;
            end else begin
                m_pos = nxt;
            end
        end
        m_prev = mueva;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: posx=%0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs for one clock and sample just after the edge
    task automatic cyc(input logic r, input logic m);
        RST   = r;
        mueva = m;
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
    endtask

    typedef struct {
        logic r;
        logic m;
        int   exp;
    } vec_t;

    initial begin
        vec_t vecs[$];
        RST   = 1'b0;
        mueva = 1'b0;

        vecs = '{
            '{1'b0, 1'b0, 16}, '{1'b0, 1'b0, 16}, '{1'b0, 1'b0, 16},
            '{1'b1, 1'b0, 16},
            '{1'b1, 1'b1, 24}, '{1'b1, 1'b1, 24}, '{1'b1, 1'b1, 24},
            '{1'b1, 1'b1, 24}, '{1'b1, 1'b1, 24},
            '{1'b1, 1'b0, 24}, '{1'b1, 1'b1, 32}, '{1'b1, 1'b0, 32},
            '{1'b0, 1'b1, 16}, '{1'b1, 1'b1, 16}, '{1'b1, 1'b1, 16},
            '{1'b1, 1'b0, 16}, '{1'b1, 1'b1, 24}, '{1'b1, 1'b0, 24}
        };
        foreach (vecs[i]) begin
            cyc(vecs[i].r, vecs[i].m);
            chk($sformatf("vec%0d", i), posx, vecs[i].exp);
        end

        // Right bounce
        cyc(1'b0, 1'b0);
        chk("rb_reset", posx, 16);
        for (int i = 0; i < 67; i++) tick();
        chk("rb_before", posx, 552);
        tick();
        chk("rb_limit", posx, 560);
        tick();
`ifdef MACHINE_SPEEDUP_EN
        chk("rb_after", posx, 551);
        tick();
        chk("rb_after2", posx, 542);
`else
        chk("rb_after", posx, 552);
        // Left bounce: walk down to 24, then hit 16 and turn
        for (int i = 0; i < 66; i++) tick();
        chk("lb_before", posx, 24);
        tick();
        chk("lb_limit", posx, 16);
        tick();
        chk("lb_after", posx, 24);
`endif

        // Reset mid-run with mueva held high
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 23; i++) tick();
        chk("mr_at200", posx, 200);
        cyc(1'b1, 1'b1);
        chk("mr_step", posx, 208);
        cyc(1'b0, 1'b1);
        chk("mr_reset", posx, 16);
        cyc(1'b1, 1'b1);
        chk("mr_hold1", posx, 16);
        cyc(1'b1, 1'b1);
        chk("mr_hold2", posx, 16);
        cyc(1'b1, 1'b0);
        chk("mr_fall", posx, 16);
        cyc(1'b1, 1'b1);
        chk("mr_rise", posx, 24);

        // Random stimulus against the model; long tick runs to reach both walls
        for (int i = 0; i < 6000; i++) begin
            logic r;
            logic m;
            r = ($urandom_range(0, 499) != 0);
            m = ($urandom_range(0, 2) != 0) ? ~mueva : mueva;
            cyc(r, m);
            chk("rand", posx, m_pos);
            if (posx < X_MIN || posx > X_MAX) chk("rand_range", posx, m_pos + 100000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
